// File: rtl/multi_port_fifo.sv
// rtl/multi_port_fifo.sv - multi-port first-word-fall-through FIFO with register storage
//
// Purpose: accepts up to WRITE_PORTS entries and retires up to READ_PORTS
// entries per clock. A push is all-or-nothing. Sparse push masks are
// compacted in ascending lane order. A pop retires the contiguous run of set
// bits starting at lane 0. All outputs depend only on registered state.
//
// Ports:
//   clk          - clock; all state updates on the rising edge
//   rst          - synchronous active-high reset
//   flush_i      - synchronous clear of all contents
//   push_i       - per-lane push request (WRITE_PORTS bits)
//   data_i       - per-lane write data; lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   push_ready_o - free slots >= WRITE_PORTS
//   pop_i        - per-lane pop request (READ_PORTS bits)
//   valid_o      - valid_o[i] = usage_o > i
//   data_o       - i-th oldest entry at [i*DATA_WIDTH +: DATA_WIDTH]
//   usage_o      - stored entry count
//   free_o       - DEPTH - usage_o
module multi_port_fifo #(
    parameter int DEPTH       = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int WRITE_PORTS = 2,
    parameter int READ_PORTS  = 2,
    localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush_i,
    input  logic [WRITE_PORTS-1:0]            push_i,
    input  logic [WRITE_PORTS*DATA_WIDTH-1:0] data_i,
    output logic                              push_ready_o,
    input  logic [READ_PORTS-1:0]             pop_i,
    output logic [READ_PORTS-1:0]             valid_o,
    output logic [READ_PORTS*DATA_WIDTH-1:0]  data_o,
    output logic [CNT_WIDTH-1:0]              usage_o,
    output logic [CNT_WIDTH-1:0]              free_o
);

    localparam int PW        = CNT_WIDTH + 1;
    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [CNT_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [CNT_WIDTH-1:0]  n_push;
    logic [CNT_WIDTH-1:0]  n_pop;
    logic [CNT_WIDTH-1:0]  wr_slot;
    logic                  pop_stop;

    // (ptr + off) mod DEPTH. ptr < DEPTH and off <= DEPTH, so the sum is below
    // 2*DEPTH and a single conditional subtract suffices for any DEPTH.
    function automatic logic [CNT_WIDTH-1:0] wrap_add(input logic [CNT_WIDTH-1:0] ptr,
                                                      input logic [CNT_WIDTH-1:0] off);
        logic [PW-1:0] sum;
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= PW'(DEPTH)) begin
            sum = sum - PW'(DEPTH);
        end
        return sum[CNT_WIDTH-1:0];
    endfunction

    assign usage_o      = count_q;
    assign free_o       = CNT_WIDTH'(DEPTH) - count_q;
    assign push_ready_o = (free_o >= CNT_WIDTH'(WRITE_PORTS));

    for (genvar i = 0; i < READ_PORTS; i++) begin : g_rd
        logic [CNT_WIDTH-1:0] rd_slot;
        assign rd_slot                             = wrap_add(rd_ptr_q, CNT_WIDTH'(i));
        assign valid_o[i]                          = (count_q > CNT_WIDTH'(i));
        assign data_o[i*DATA_WIDTH +: DATA_WIDTH]  = mem_q[rd_slot[PTR_WIDTH-1:0]];
    end

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        n_push   = '0;
        n_pop    = '0;
        wr_slot  = '0;
        pop_stop = 1'b0;

        if (!flush_i) begin
            // Compaction: the running count of set lanes is the slot offset.
            if (push_ready_o && !rst) begin
                for (int k = 0; k < WRITE_PORTS; k++) begin
                    if (push_i[k]) begin
                        wr_slot = wrap_add(wr_ptr_q, n_push);
                        mem_d[wr_slot[PTR_WIDTH-1:0]] = data_i[k*DATA_WIDTH +: DATA_WIDTH];
                        n_push = n_push + CNT_WIDTH'(1);
                    end
                end
            end
            // Only the unbroken run of (pop & valid) from lane 0 is retired.
            for (int i = 0; i < READ_PORTS; i++) begin
                if (!pop_stop && pop_i[i] && valid_o[i]) begin
                    n_pop = n_pop + CNT_WIDTH'(1);
                end else begin
                    pop_stop = 1'b1;
                end
            end
            wr_ptr_d = wrap_add(wr_ptr_q, n_push);
            rd_ptr_d = wrap_add(rd_ptr_q, n_pop);
            count_d  = count_q + n_push - n_pop;
        end else begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is intentionally not reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_multi_port_fifo.sv
// tb/tb_multi_port_fifo.sv - scoreboard bench for multi_port_fifo
module tb_multi_port_fifo;

    localparam int DEPTH = 6;
    localparam int DW    = 8;
    localparam int WP    = 2;
    localparam int RP    = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              flush_i;
    logic [WP-1:0]     push_i;
    logic [WP*DW-1:0]  data_i;
    logic              push_ready_o;
    logic [RP-1:0]     pop_i;
    logic [RP-1:0]     valid_o;
    logic [RP*DW-1:0]  data_o;
    logic [CW-1:0]     usage_o;
    logic [CW-1:0]     free_o;

    multi_port_fifo #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .WRITE_PORTS(WP), .READ_PORTS(RP)
    ) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .push_i(push_i), .data_i(data_i),
        .push_ready_o(push_ready_o), .pop_i(pop_i), .valid_o(valid_o),
        .data_o(data_o), .usage_o(usage_o), .free_o(free_o)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] exp_q[$];
    int  model_cnt = 0;
    int  pend_push = 0;
    bit  clr       = 1'b0;
    bit  mon_en    = 1'b0;
    int  n_tests   = 0;
    int  n_fail    = 0;
    logic [7:0] ctr;

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Driver: one cycle of stimulus; accepted pushes go straight to the scoreboard.
    task automatic step(input logic [1:0] p, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [1:0] pp, input logic fl, input logic rs);
        push_i    = p;
        data_i    = {d1, d0};
        pop_i     = pp;
        flush_i   = fl;
        rst       = rs;
        clr       = fl | rs;
        pend_push = 0;
        if (!clr && (DEPTH - model_cnt >= WP)) begin
            if (p[0]) begin exp_q.push_back(d0); pend_push++; end
            if (p[1]) begin exp_q.push_back(d1); pend_push++; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
    endtask

    // Monitor: mid-cycle, compares visible state with the model, then retires pops.
    always @(negedge clk) begin : mon
        int np;
        bit stop;
        np   = 0;
        stop = 1'b0;
        if (mon_en) begin
            chk("usage", int'(usage_o), model_cnt);
            chk("free", int'(free_o), DEPTH - model_cnt);
            chk("push_ready", int'(push_ready_o), (DEPTH - model_cnt >= WP) ? 1 : 0);
            for (int i = 0; i < RP; i++) begin
                chk($sformatf("valid[%0d]", i), int'(valid_o[i]), (i < model_cnt) ? 1 : 0);
                if (i < model_cnt)
                    chk($sformatf("data[%0d]", i), int'(data_o[i*DW +: DW]), int'(exp_q[i]));
            end
        end
        if (clr) begin
            exp_q.delete();
            model_cnt = 0;
        end else begin
            for (int i = 0; i < RP; i++) begin
                if (!stop && pop_i[i] === 1'b1 && i < model_cnt) np++;
                else stop = 1'b1;
            end
            for (int i = 0; i < np; i++) void'(exp_q.pop_front());
            model_cnt = model_cnt + pend_push - np;
        end
    end

    initial begin
        rst = 1'b1; flush_i = 1'b0; push_i = '0; pop_i = '0; data_i = '0;
        clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Reset state then basic order
        idle(1);
        step(2'b11, 8'hA0, 8'hA1, 2'b00, 1'b0, 1'b0);
        step(2'b11, 8'hA2, 8'hA3, 2'b00, 1'b0, 1'b0);
        idle(1);
        step(2'b00, 8'h00, 8'h00, 2'b11, 1'b0, 1'b0);
        idle(1);
        step(2'b00, 8'h00, 8'h00, 2'b11, 1'b0, 1'b0);

        // Sparse push compaction, no pass-through
        step(2'b10, 8'hEE, 8'h55, 2'b00, 1'b0, 1'b0);
        idle(1);
        step(2'b00, 8'h00, 8'h00, 2'b01, 1'b0, 1'b0);

        // Fill to 5, backpressure, non-prefix pop
        step(2'b11, 8'h10, 8'h11, 2'b00, 1'b0, 1'b0);
        step(2'b11, 8'h12, 8'h13, 2'b00, 1'b0, 1'b0);
        step(2'b01, 8'h14, 8'h00, 2'b00, 1'b0, 1'b0);
        step(2'b11, 8'hF0, 8'hF1, 2'b00, 1'b0, 1'b0);
        step(2'b00, 8'h00, 8'h00, 2'b10, 1'b0, 1'b0);
        step(2'b00, 8'h00, 8'h00, 2'b01, 1'b0, 1'b0);
        step(2'b00, 8'h00, 8'h00, 2'b11, 1'b0, 1'b0);
        idle(1);

        // Wrap-around streaming from usage 2
        ctr = 8'h20;
        for (int i = 0; i < 20; i++) begin
            step(2'b11, ctr, ctr + 8'd1, 2'b11, 1'b0, 1'b0);
            ctr = ctr + 8'd2;
        end
        idle(1);

        // Flush priority, then reset+flush priority
        step(2'b11, 8'h30, 8'h31, 2'b00, 1'b0, 1'b0);
        idle(1);
        step(2'b11, 8'h32, 8'h33, 2'b11, 1'b1, 1'b0);
        idle(1);
        step(2'b11, 8'h40, 8'h41, 2'b00, 1'b0, 1'b0);
        step(2'b11, 8'h42, 8'h43, 2'b01, 1'b1, 1'b1);
        idle(1);
        step(2'b11, 8'hB0, 8'hB1, 2'b00, 1'b0, 1'b0);
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            step(2'($urandom), 8'($urandom), 8'($urandom), 2'($urandom),
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 59) == 0));
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
